// File: rtl/link_pkg.sv
// ---------------------------------------------------------------------------
// link_pkg
// Shared definitions for both ends of the byte link: the 32->8 serializer and
// the 8->32 deserializer (conv8_32). Both ends take the byte width, the number
// of bytes per word and the byte-index type from here, so they always agree on
// how a word is split into bytes and in which order the bytes travel.
//
// Contents:
//   BYTE_W          width of one byte on the lane
//   BYTES_PER_WORD  number of bytes making up one word
//   WORD_W          derived word width
//   byte_idx_t      index of a byte within a word (0 = most significant byte)
//   word_byte()     pick byte k of a word, MSB-first
// ---------------------------------------------------------------------------
package link_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

    typedef logic [1:0] byte_idx_t;

    // Byte 0 is the first byte on the lane and sits in the top bits of the
    // word, so byte k occupies bits [WORD_W-1-k*BYTE_W -: BYTE_W].
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] word,
                                                    input byte_idx_t         idx);
        return word[WORD_W-1-int'(idx)*BYTE_W -: BYTE_W];
    endfunction

endpackage

// File: rtl/conv8_32.sv
// ---------------------------------------------------------------------------
// conv8_32
// Byte-to-word deserializer for the receive side of the byte link. Collects
// NUM consecutive valid bytes (first byte = most significant), then presents
// the assembled word with a one-cycle valid pulse. A byte run that stops
// before the word is complete is thrown away and flagged with a one-cycle err.
//
// Ports:
//   clk_4f    in   byte-rate clock, everything on its rising edge
//   reset     in   synchronous, active-high reset
//   in        in   byte valid
//   in_data   in   byte lane (IN_W bits)
//   out       out  word valid, one-cycle pulse
//   out_data  out  last completed word (OUT_W bits), held between pulses
//   err       out  one-cycle pulse when a partial word is aborted
//   busy      out  high while a word is partially assembled
// ---------------------------------------------------------------------------
module conv8_32
    import link_pkg::*;
#(
    parameter int IN_W = BYTE_W,
    parameter int NUM  = BYTES_PER_WORD
)(
    input  logic                 clk_4f,
    input  logic                 reset,
    input  logic                 in,
    input  logic [IN_W-1:0]      in_data,
    output logic                 out,
    output logic [IN_W*NUM-1:0]  out_data,
    output logic                 err,
    output logic                 busy
);

    localparam int OUT_W = IN_W * NUM;
    localparam int SR_W  = OUT_W - IN_W;
    localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  sr;

    // Byte assembly. cnt counts bytes already held in sr. The final byte of a
    // word is never stored in sr: it is concatenated straight into out_data,
    // so the word appears the cycle after its last byte and cnt can wrap to 0
    // in the same edge, allowing back-to-back words with no idle cycle.
    // Dropping valid mid-word discards the partial bytes (cnt back to 0) and
    // raises err for one cycle; sr is left as is because the next word shifts
    // its contents out completely before they are used. Reset mid-word is a
    // silent drop, so it takes priority over the abort path.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            cnt      <= '0;
            sr       <= '0;
            out_data <= '0;
            out      <= 1'b0;
            err      <= 1'b0;
        end else begin
            out <= 1'b0;
            err <= 1'b0;
            if (in) begin
                if (cnt == CNT_LAST) begin
                    out_data <= {sr, in_data};
                    out      <= 1'b1;
                    cnt      <= '0;
                end else begin
                    sr  <= SR_W'({sr, in_data});
                    cnt <= cnt + CNT_ONE;
                end
            end else if (cnt != '0) begin
                err <= 1'b1;
                cnt <= '0;
            end
        end
    end

    // busy comes straight from the registered count, so it has no path from
    // the inputs.
    always_comb begin
        busy = (cnt != '0);
    end

endmodule
